reg_slice_pipe: RTL

Parametrised multi-stage valid/ready register-slice pipeline for timing closure on long handshake paths. The block chains NUM_STAGES slices, and the type of each stage is selected independently. It adds a true skid-buffer backward stage that breaks the m_rdy->s_rdy combinational path, a synchronous flush, and an occupancy count. Place it between any valid/ready producer/consumer pair, e.g. across floorplan partitions.

---
 rtl/reg_slice_pkg.sv | 26 ++
 rtl/reg_slice_stage.sv | 110 +++++++++++
 rtl/reg_slice_pipe.sv | 70 +++++++
 3 files changed

// File: rtl/reg_slice_pkg.sv
// Shared types and helpers for the valid/ready register-slice pipeline.
package reg_slice_pkg;

  typedef enum logic [1:0] {
    RS_PASS = 2'd0,
    RS_FWD  = 2'd1,
    RS_BWD  = 2'd2,
    RS_FULL = 2'd3
  } rs_type_e;

  function automatic logic [1:0] rs_capacity(rs_type_e t);
    case (t)
      RS_PASS:        return 2'd0;
      RS_FWD, RS_BWD: return 2'd1;
      default:        return 2'd2;
    endcase
  endfunction

  function automatic logic rs_latency(rs_type_e t);
    case (t)
      RS_FWD, RS_FULL: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// One valid/ready slice; RS_TYPE picks pass, forward, skid or 2-entry full slice.
// Handshake: a beat moves when vld && rdy on the same edge; a producer holding
// vld high must keep pld stable until rdy, and vld never waits on rdy.
module reg_slice_stage
  import reg_slice_pkg::*;
#(
  parameter int       PLD_WIDTH = 32,
  parameter rs_type_e RS_TYPE   = RS_FULL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [PLD_WIDTH-1:0] in_pld,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [PLD_WIDTH-1:0] out_pld,
  output logic [1:0]           count
);

  generate
    if (RS_TYPE == RS_PASS) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, flush};
      assign in_rdy  = out_rdy;
      assign out_vld = in_vld;
      assign out_pld = in_pld;
      assign count   = 2'd0;
    end else if (RS_TYPE == RS_FWD) begin : g_fwd
      logic                 vld_r;
      logic [PLD_WIDTH-1:0] pld_r;
      assign in_rdy  = !vld_r || out_rdy;
      assign out_vld = vld_r;
      assign out_pld = pld_r;
      assign count   = {1'b0, vld_r};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_r <= 1'b0;
          pld_r <= '0;
        end else if (flush) begin
          vld_r <= 1'b0;
        end else if (in_vld && in_rdy) begin
          vld_r <= 1'b1;
          pld_r <= in_pld;
        end else if (out_rdy) begin
          vld_r <= 1'b0;
        end
      end
    end else if (RS_TYPE == RS_BWD) begin : g_bwd
      // Ready comes only from skid_vld, which cuts the out_rdy -> in_rdy path.
      logic                 skid_vld;
      logic [PLD_WIDTH-1:0] skid_pld;
      assign in_rdy  = !skid_vld;
      assign out_vld = in_vld || skid_vld;
      assign out_pld = skid_vld ? skid_pld : in_pld;
      assign count   = {1'b0, skid_vld};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_vld <= 1'b0;
          skid_pld <= '0;
        end else if (flush) begin
          skid_vld <= 1'b0;
        end else if (in_vld && in_rdy && !out_rdy) begin
          skid_vld <= 1'b1;
          skid_pld <= in_pld;
        end else if (skid_vld && out_rdy) begin
          skid_vld <= 1'b0;
        end
      end
    end else begin : g_full
      // Pointers carry a wrap bit: equal means empty, differing only in MSB means full.
      logic [1:0]           wr_ptr;
      logic [1:0]           rd_ptr;
      logic [PLD_WIDTH-1:0] mem [2];
      logic                 full;
      logic                 empty;
      logic                 push;
      logic                 pop;
      assign full    = (wr_ptr ^ rd_ptr) == 2'b10;
      assign empty   = wr_ptr == rd_ptr;
      assign in_rdy  = !full;
      assign out_vld = !empty;
      assign out_pld = mem[rd_ptr[0]];
      assign push    = in_vld && !full;
      assign pop     = out_rdy && !empty;
      assign count   = wr_ptr - rd_ptr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr <= 2'd0;
          rd_ptr <= 2'd0;
          mem[0] <= '0;
          mem[1] <= '0;
        end else if (flush) begin
          wr_ptr <= 2'd0;
          rd_ptr <= 2'd0;
        end else begin
          if (push) begin
            mem[wr_ptr[0]] <= in_pld;
            wr_ptr         <= wr_ptr + 2'd1;
          end
          if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/reg_slice_pipe.sv
// Chain of NUM_STAGES valid/ready slices with per-stage type, boundary flush
// gating and a count of beats held across all stages.
module reg_slice_pipe
  import reg_slice_pkg::*;
#(
  parameter int                      PLD_WIDTH  = 32,
  parameter int                      NUM_STAGES = 2,
  parameter logic [2*NUM_STAGES-1:0] STAGE_TYPE = {NUM_STAGES{2'd3}},
  localparam int                     CNT_W      = $clog2(2*NUM_STAGES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [PLD_WIDTH-1:0] s_pld,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [PLD_WIDTH-1:0] m_pld,
  output logic [CNT_W-1:0]     occupancy
);

  generate
    if (NUM_STAGES < 1) begin : g_bad_cfg
      $error("reg_slice_pipe: NUM_STAGES must be at least 1");
    end
  endgenerate

  logic                 stg_vld [NUM_STAGES+1];
  logic                 stg_rdy [NUM_STAGES+1];
  logic [PLD_WIDTH-1:0] stg_pld [NUM_STAGES+1];
  logic [1:0]           stg_cnt [NUM_STAGES];

  // Flush blocks both boundary handshakes so nothing enters or leaves that cycle.
  assign stg_vld[0]          = s_vld && !flush;
  assign stg_pld[0]          = s_pld;
  assign s_rdy               = stg_rdy[0] && !flush;
  assign m_vld               = stg_vld[NUM_STAGES] && !flush;
  assign m_pld               = stg_pld[NUM_STAGES];
  assign stg_rdy[NUM_STAGES] = m_rdy && !flush;

  generate
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      reg_slice_stage #(
        .PLD_WIDTH (PLD_WIDTH),
        .RS_TYPE   (rs_type_e'(STAGE_TYPE[2*i +: 2]))
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_vld  (stg_vld[i]),
        .in_rdy  (stg_rdy[i]),
        .in_pld  (stg_pld[i]),
        .out_vld (stg_vld[i+1]),
        .out_rdy (stg_rdy[i+1]),
        .out_pld (stg_pld[i+1]),
        .count   (stg_cnt[i])
      );
    end
  endgenerate

  // Every per-stage count is decoded straight from its flops, so this sum has no input path.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occupancy = occupancy + CNT_W'(stg_cnt[i]);
    end
  end

endmodule
